obf_seqctl: RTL
===============

// Module: obf_seqctl
// PURPOSE
//  Sequencer for the obfuscated-instruction generator (obf_insngen). Accepts one reference instruction
//  from IF, latches it with the current key, and steps the substitution PPC until the generator flags
//  the last micro-instruction. It emits one obfuscated instruction per unstalled cycle to ID and holds
//  IF off while an expansion is in progress. Sits between the IF output register and the ID stage.
// PARAMETERS
//  PPC_W   4  width of PPC step counter; must equal `OBF_PPC_WIDTH
//  KEY_W   2  width of obfuscation key; must equal `OBF_KEY_WIDTH
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous reset, active-high
//  if_insn_i      in   32     reference instruction from IF
//  if_valid_i     in   1      if_insn_i valid
//  if_ready_o     out  1      sequencer accepts if_insn_i this cycle
//  key_i          in   KEY_W  live obfuscation key
//  obf_en_i       in   1      1 = expand via generator, 0 = pass-through
//  flush_i        in   1      pipeline flush (branch/exception)
//  id_stall_i     in   1      ID cannot accept output this cycle
//  gen_ref_o      out  32     latched reference instruction to generator
//  gen_ppc_o      out  PPC_W  current substitution step to generator
//  gen_key_o      out  KEY_W  latched key to generator
//  gen_insn_i     in   32     generator obfuscated instruction
//  gen_last_i     in   1      generator: this step is the last
//  gen_skip_i     in   1      generator: this step is suppressed (not issued)
//  id_insn_o      out  32     instruction to ID (registered)
//  id_valid_o     out  1      id_insn_o valid (registered)
//  busy_o         out  1      expansion in progress (state == EXPAND)
//  err_o          out  1      one-cycle pulse: watchdog abort
// BEHAVIOUR
//  Reset: state IDLE, gen_ref_o=0, gen_ppc_o=0, gen_key_o=0, id_insn_o=0, id_valid_o=0, err_o=0.
//  Priority per cycle: rst > flush_i > id_stall_i > normal operation.
//  if_ready_o = (state==IDLE) & !id_stall_i & !flush_i  (combinational).
//  IDLE, accept (if_valid_i & if_ready_o):
//   - obf_en_i=1: gen_ref_o<=if_insn_i, gen_key_o<=key_i, gen_ppc_o<=0, ->EXPAND; id_valid_o<=0.
//   - obf_en_i=0: id_insn_o<=if_insn_i, id_valid_o<=1, stay IDLE (1-cycle latency pass-through).
//  IDLE, no accept and !id_stall_i: id_valid_o<=0.
//  EXPAND, !id_stall_i, each cycle:
//   - gen_skip_i=0: id_insn_o<=gen_insn_i, id_valid_o<=1; gen_skip_i=1: id_valid_o<=0.
//   - gen_last_i=1: gen_ppc_o<=0, ->IDLE. Else gen_ppc_o<=gen_ppc_o+1.
//   - Watchdog: gen_ppc_o==2^PPC_W-1 & gen_last_i=0 -> treat as last (->IDLE, ppc<=0), err_o<=1 for 1 cycle.
//  id_stall_i=1: all registers hold (state, ppc, id_insn_o, id_valid_o); err_o<=0.
//  gen_last_i & gen_skip_i together: expansion ends with no issue that cycle.
//  Key and ref insn are frozen during EXPAND; key_i changes affect only the next accepted insn.
//  obf_en_i is sampled only at accept; toggling it mid-expansion has no effect.
//  flush_i: state<=IDLE, gen_ppc_o<=0, id_valid_o<=0, no accept that cycle; overrides id_stall_i.
//  gen_ppc_o never wraps: watchdog forces return to 0 at max.
// CONFIGURATION
//  OBF_SEQCTL_STATS_EN defined: adds outputs stat_exp_o[31:0] (expansions completed, incl. aborts)
//   and stat_uop_o[31:0] (instructions issued with id_valid_o, incl. pass-through); both reset to 0
//   by rst only (not flush), saturate at 32'hFFFFFFFF, increment on the cycle the event is registered.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  Pass-through: obf_en_i=0, valid insn 0x9C210004 -> next cycle id_insn_o=0x9C210004, id_valid_o=1, busy_o=0.
//  3-step expansion: generator model last at ppc=2, no skips -> gen_ppc_o 0,1,2; 3 consecutive
//   id_valid_o pulses with model insns; if_ready_o=0 for those 3 cycles; IDLE after.
//  Skip step: skip at ppc=1 of 3 -> only 2 issued insns (ppc 0 and 2); ppc still advances 0,1,2.
//  Stall mid-expansion: id_stall_i=1 for 2 cycles at ppc=1 -> ppc, id_insn_o, id_valid_o frozen; resumes at ppc=1.
//  Flush at ppc=2 of 5-step expansion -> next cycle IDLE, ppc=0, id_valid_o=0; new insn accepted next cycle.
//  Watchdog: gen_last_i tied 0, PPC_W=4 -> 16 steps issued, err_o pulses once at ppc=15, returns IDLE;
//   with OBF_SEQCTL_STATS_EN, stat_exp_o=1, stat_uop_o=16.

Source files
------------

// File: rtl/obf_seqctl.sv
// rtl/obf_seqctl.sv - obfuscated-instruction sequencer between IF and ID (optional OBF_SEQCTL_STATS_EN counters)
module obf_seqctl #(
   parameter int PPC_W = 4,
   parameter int KEY_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       if_insn_i,
   input  logic              if_valid_i,
   output logic              if_ready_o,
   input  logic [KEY_W-1:0]  key_i,
   input  logic              obf_en_i,
   input  logic              flush_i,
   input  logic              id_stall_i,
   output logic [31:0]       gen_ref_o,
   output logic [PPC_W-1:0]  gen_ppc_o,
   output logic [KEY_W-1:0]  gen_key_o,
   input  logic [31:0]       gen_insn_i,
   input  logic              gen_last_i,
   input  logic              gen_skip_i,
   output logic [31:0]       id_insn_o,
   output logic              id_valid_o,
   output logic              busy_o,
   output logic              err_o
`ifdef OBF_SEQCTL_STATS_EN
  ,output logic [31:0]       stat_exp_o,
   output logic [31:0]       stat_uop_o
`endif
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_EXPAND = 1'b1
   } state_t;

   localparam logic [PPC_W-1:0] PPC_MAX = '1;
   localparam logic [PPC_W-1:0] PPC_ONE = {{(PPC_W-1){1'b0}}, 1'b1};

   state_t             r_state;
   state_t             w_state_nxt;
   logic [31:0]        r_ref;
   logic [31:0]        w_ref_nxt;
   logic [PPC_W-1:0]   r_ppc;
   logic [PPC_W-1:0]   w_ppc_nxt;
   logic [KEY_W-1:0]   r_key;
   logic [KEY_W-1:0]   w_key_nxt;
   logic [31:0]        r_id_insn;
   logic [31:0]        w_id_insn_nxt;
   logic               r_id_valid;
   logic               w_id_valid_nxt;
   logic               r_err;
   logic               w_err_nxt;
   logic               w_accept;
   logic               w_at_max;
   logic               w_end;

   assign if_ready_o = (r_state == S_IDLE) & !id_stall_i & !flush_i;
   assign w_accept   = if_valid_i & if_ready_o;
   // The step counter must never wrap: reaching its top value ends the expansion regardless.
   assign w_at_max   = (r_ppc == PPC_MAX);
   assign w_end      = gen_last_i | w_at_max;

   assign gen_ref_o  = r_ref;
   assign gen_ppc_o  = r_ppc;
   assign gen_key_o  = r_key;
   assign id_insn_o  = r_id_insn;
   assign id_valid_o = r_id_valid;
   assign busy_o     = (r_state == S_EXPAND);
   assign err_o      = r_err;

   // Next-state and next-output selection: flush beats stall beats normal sequencing.
   always_comb begin
      w_state_nxt    = r_state;
      w_ref_nxt      = r_ref;
      w_ppc_nxt      = r_ppc;
      w_key_nxt      = r_key;
      w_id_insn_nxt  = r_id_insn;
      w_id_valid_nxt = r_id_valid;
      w_err_nxt      = 1'b0;
      if (flush_i) begin
         w_state_nxt    = S_IDLE;
         w_ppc_nxt      = '0;
         w_id_valid_nxt = 1'b0;
      end else if (!id_stall_i) begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (obf_en_i) begin
                     w_ref_nxt      = if_insn_i;
                     w_key_nxt      = key_i;
                     w_ppc_nxt      = '0;
                     w_state_nxt    = S_EXPAND;
                     w_id_valid_nxt = 1'b0;
                  end else begin
                     w_id_insn_nxt  = if_insn_i;
                     w_id_valid_nxt = 1'b1;
                  end
               end else begin
                  w_id_valid_nxt = 1'b0;
               end
            end
            S_EXPAND: begin
               if (gen_skip_i) begin
                  w_id_valid_nxt = 1'b0;
               end else begin
                  w_id_insn_nxt  = gen_insn_i;
                  w_id_valid_nxt = 1'b1;
               end
               if (w_end) begin
                  w_ppc_nxt   = '0;
                  w_state_nxt = S_IDLE;
                  w_err_nxt   = w_at_max & !gen_last_i;
               end else begin
                  w_ppc_nxt   = r_ppc + PPC_ONE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ref      <= '0;
         r_ppc      <= '0;
         r_key      <= '0;
         r_id_insn  <= '0;
         r_id_valid <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ref      <= w_ref_nxt;
         r_ppc      <= w_ppc_nxt;
         r_key      <= w_key_nxt;
         r_id_insn  <= w_id_insn_nxt;
         r_id_valid <= w_id_valid_nxt;
         r_err      <= w_err_nxt;
      end
   end

`ifdef OBF_SEQCTL_STATS_EN
   logic [31:0] r_stat_exp;
   logic [31:0] r_stat_uop;
   logic        w_issue;
   logic        w_exp_done;

   // A stalled cycle only holds id_valid_o, so it is never a fresh issue.
   assign w_issue    = w_id_valid_nxt & !flush_i & !id_stall_i;
   assign w_exp_done = (r_state == S_EXPAND) & w_end & !flush_i & !id_stall_i;
   assign stat_exp_o = r_stat_exp;
   assign stat_uop_o = r_stat_uop;

   // Saturating event counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_exp <= '0;
         r_stat_uop <= '0;
      end else begin
         if (w_exp_done && (r_stat_exp != 32'hFFFF_FFFF)) begin
            r_stat_exp <= r_stat_exp + 32'd1;
         end
         if (w_issue && (r_stat_uop != 32'hFFFF_FFFF)) begin
            r_stat_uop <= r_stat_uop + 32'd1;
         end
      end
   end
`endif

endmodule
